// File: rtl/banked_reg_read_file_pkg.sv
// Processor-wide register-file defaults shared by the datapath blocks.
package banked_reg_read_file_pkg;

  localparam int RF_WIDTH    = 16;
  localparam int RF_DEPTH    = 8;
  localparam int RF_ADDR_W   = $clog2(RF_DEPTH);
  localparam int RF_ZERO_IDX = 0;

endpackage

// File: rtl/banked_reg_read_file_rf_read_port.sv
// One registered read port: zero / bypass / array select feeding the output register.
module rf_read_port
  import banked_reg_read_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [WIDTH-1:0]  mem_i [DEPTH],
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              rd_valid_o
);

  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  // Later assignments win: zero register beats bypass beats the stored value.
  always_comb begin
    rd_data_d = mem_i[rd_addr_i];
    if ((BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i))
      rd_data_d = wr_data_i;
    if ((ZERO_REG != 0) && (rd_addr_i == ADDR_W'(RF_ZERO_IDX)))
      rd_data_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i)
        rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/banked_reg_read_file.sv
// Register file with one synchronous write port and NUM_RD registered read ports.
module banked_reg_read_file
  import banked_reg_read_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [DEPTH-1:0]         busy_mask
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_q;
  logic             wr_commit;

  // A write to the hardwired-zero register never lands and never flags a hazard.
  assign wr_commit = wr_en &&
                     !((ZERO_REG != 0) && (wr_addr == ADDR_W'(RF_ZERO_IDX)));

  always_comb begin
    busy_d = '0;
    if (wr_commit)
      busy_d = DEPTH'(1) << wr_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_commit)
        mem_q[wr_addr] <= wr_data;
      busy_q <= busy_d;
    end
  end

  assign busy_mask = busy_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    rf_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_en_i    (rd_en[g]),
      .rd_addr_i  (rd_addr[g*ADDR_W +: ADDR_W]),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .mem_i      (mem_q),
      .rd_data_o  (rd_data[g*WIDTH +: WIDTH]),
      .rd_valid_o (rd_valid[g])
    );
  end

endmodule

// File: tb/tb_banked_reg_read_file.sv
// Randomised and directed checks of three register-file configurations against a state model.
module tb_banked_reg_read_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Shared stimulus for A (ZERO_REG=0, BYPASS=1) and B (ZERO_REG=1, BYPASS=0)
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_valid_a, rd_valid_b;
  logic [7:0]  busy_a, busy_b;

  // C: WIDTH=32, DEPTH=32, NUM_RD=3, ZERO_REG=1, BYPASS=1
  logic        c_wr_en;
  logic [4:0]  c_wr_addr;
  logic [31:0] c_wr_data;
  logic [2:0]  c_rd_en;
  logic [14:0] c_rd_addr;
  logic [95:0] rd_data_c;
  logic [2:0]  rd_valid_c;
  logic [31:0] busy_c;

  banked_reg_read_file #(.ZERO_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .busy_mask(busy_a));

  banked_reg_read_file #(.ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .busy_mask(busy_b));

  banked_reg_read_file #(.WIDTH(32), .DEPTH(32), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
    .busy_mask(busy_c));

  // Reference state: register contents and the expected output registers.
  logic [15:0] mem_a [8];
  logic [15:0] mem_b [8];
  logic [31:0] mem_c [32];
  logic [15:0] ea [2];
  logic [15:0] eb [2];
  logic [31:0] ec [3];
  logic [1:0]  eva, evb;
  logic [2:0]  evc;
  logic [7:0]  eba, ebb;
  logic [31:0] ebc;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_data",  rd_data_a,  {ea[1], ea[0]});
    chk("a_valid", rd_valid_a, eva);
    chk("a_busy",  busy_a,     eba);
    chk("b_data",  rd_data_b,  {eb[1], eb[0]});
    chk("b_valid", rd_valid_b, evb);
    chk("b_busy",  busy_b,     ebb);
    chk("c_data",  rd_data_c,  {ec[2], ec[1], ec[0]});
    chk("c_valid", rd_valid_c, evc);
    chk("c_busy",  busy_c,     ebc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    for (int i = 0; i < 32; i++) mem_c[i] = '0;
    for (int i = 0; i < 2; i++) begin ea[i] = '0; eb[i] = '0; end
    for (int i = 0; i < 3; i++) ec[i] = '0;
    eva = '0; evb = '0; evc = '0;
    eba = '0; ebb = '0; ebc = '0;
  endtask

  // One clock: compute the post-write state, decide what each read sees, then compare.
  task automatic tick();
    logic [15:0] na [8];
    logic [15:0] nb [8];
    logic [31:0] nc [32];
    na = mem_a;
    nb = mem_b;
    nc = mem_c;
    if (wr_en) na[wr_addr] = wr_data;
    if (wr_en && wr_addr != 3'd0) nb[wr_addr] = wr_data;
    if (c_wr_en && c_wr_addr != 5'd0) nc[c_wr_addr] = c_wr_data;
    for (int p = 0; p < 2; p++) begin
      if (rd_en[p]) begin
        ea[p] = na[rd_addr[p*3 +: 3]];
        eb[p] = mem_b[rd_addr[p*3 +: 3]];
      end
    end
    for (int p = 0; p < 3; p++)
      if (c_rd_en[p]) ec[p] = nc[c_rd_addr[p*5 +: 5]];
    eva = rd_en;
    evb = rd_en;
    evc = c_rd_en;
    eba = wr_en ? (8'b1 << wr_addr) : 8'b0;
    ebb = (wr_en && wr_addr != 3'd0) ? (8'b1 << wr_addr) : 8'b0;
    ebc = (c_wr_en && c_wr_addr != 5'd0) ? (32'b1 << c_wr_addr) : 32'b0;
    @(posedge clk);
    mem_a = na;
    mem_b = nb;
    mem_c = nc;
    #1;
    check_all();
  endtask

  task automatic drv(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                     input logic [1:0] re, input logic [2:0] a0, input logic [2:0] a1);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = {a1, a0};
    tick();
  endtask

  // Asynchronous reset asserted between clock edges, released on a falling edge.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
    c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0; c_rd_en = '0; c_rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-run clears a written register
    drv(1'b1, 3'd3, 16'hBEEF, 2'b00, 3'd0, 3'd0);
    drv(1'b0, 3'd0, 16'h0000, 2'b01, 3'd3, 3'd0);
    chk("t1_pre_reset", rd_data_a[15:0], 16'hBEEF);
    mid_reset();
    drv(1'b0, 3'd0, 16'h0000, 2'b01, 3'd3, 3'd0);
    chk("t1_data",  rd_data_a[15:0], 16'h0000);
    chk("t1_valid", rd_valid_a[0],   1'b1);

    // Write then dual read
    drv(1'b1, 3'd5, 16'h1234, 2'b00, 3'd0, 3'd0);
    drv(1'b0, 3'd0, 16'h0000, 2'b11, 3'd5, 3'd2);
    chk("t2_data",  rd_data_a, {16'h0000, 16'h1234});
    chk("t2_valid", rd_valid_a, 2'b11);

    // Same-edge write and read of r7
    drv(1'b1, 3'd7, 16'h00AA, 2'b00, 3'd0, 3'd0);
    drv(1'b1, 3'd7, 16'h5555, 2'b11, 3'd7, 3'd7);
    chk("t3_bypass",   rd_data_a, {16'h5555, 16'h5555});
    chk("t3_nobypass", rd_data_b, {16'h00AA, 16'h00AA});
    drv(1'b0, 3'd0, 16'h0000, 2'b11, 3'd7, 3'd7);
    chk("t3_nobypass_later", rd_data_b, {16'h5555, 16'h5555});

    // Zero register
    drv(1'b1, 3'd0, 16'hFFFF, 2'b00, 3'd0, 3'd0);
    chk("t4_busy_zr",   busy_b, 8'h00);
    chk("t4_busy_nozr", busy_a, 8'h01);
    drv(1'b0, 3'd0, 16'h0000, 2'b10, 3'd0, 3'd0);
    chk("t4_zr",   rd_data_b[31:16], 16'h0000);
    chk("t4_nozr", rd_data_a[31:16], 16'hFFFF);

    // Hold while rd_en deasserted
    drv(1'b0, 3'd0, 16'h0000, 2'b01, 3'd5, 3'd0);
    chk("t5_read", rd_data_a[15:0], 16'h1234);
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 3'd5, 16'h9999, 2'b00, 3'd0, 3'd0);
      chk("t5_hold",  rd_data_a[15:0], 16'h1234);
      chk("t5_valid", rd_valid_a[0],   1'b0);
    end

    // Wide configuration: r31 and the top busy bit
    wr_en = 1'b0; rd_en = 2'b00;
    c_wr_en = 1'b1; c_wr_addr = 5'd31; c_wr_data = 32'hDEADBEEF; c_rd_en = 3'b000;
    tick();
    chk("t6_busy", busy_c, 32'h8000_0000);
    c_wr_en = 1'b0; c_rd_en = 3'b111; c_rd_addr = {5'd31, 5'd31, 5'd31};
    tick();
    chk("t6_data",  rd_data_c, {3{32'hDEADBEEF}});
    chk("t6_busy_clear", busy_c, 32'h0);
    chk("t6_valid", rd_valid_c, 3'b111);

    // Randomised traffic with frequent address collisions
    for (int n = 0; n < 400; n++) begin
      logic [2:0] a0, a1;
      logic [4:0] c0, c1, c2;
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom);
      wr_data = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rd_en   = 2'($urandom);
      a0 = ($urandom_range(0, 2) == 0) ? wr_addr : 3'($urandom);
      a1 = ($urandom_range(0, 2) == 0) ? wr_addr : 3'($urandom);
      rd_addr = {a1, a0};
      c_wr_en   = 1'($urandom_range(0, 1));
      c_wr_addr = 5'($urandom);
      c_wr_data = $urandom;
      c_rd_en   = 3'($urandom);
      c0 = ($urandom_range(0, 2) == 0) ? c_wr_addr : 5'($urandom);
      c1 = ($urandom_range(0, 2) == 0) ? c_wr_addr : 5'($urandom);
      c2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      c_rd_addr = {c2, c1, c0};
      tick();
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
